// File: rtl/dnn_pkg.sv
// Shared sizes, types and layer geometry for the dense-section weight loader.
// LNN is kept in dnn_top order, so layer k reads it from the back.
package dnn_pkg;

    localparam int NumLayers    = 4;
    localparam int MaxNumNerves = 6;
    localparam int M_W_BitSize  = 16;
    localparam int ImageSize    = 16;
    localparam int LNN [NumLayers] = '{2, 3, 5, 6};

    typedef enum logic [1:0] {IDLE, CLEAR, LOAD, DONE} weight_ld_state_t;
    typedef logic [MaxNumNerves-1:0][M_W_BitSize-1:0] weight_row_t;

    function automatic int rows_for_layer(input int k);
        if (k == 0)
            return ImageSize;
        else
            return LNN[NumLayers-k];
    endfunction

    function automatic logic [MaxNumNerves-1:0] lane_mask(input int k);
        logic [MaxNumNerves-1:0] m;
        m = '0;
        for (int i = 0; i < MaxNumNerves; i++)
            m[i] = (i >= MaxNumNerves - LNN[NumLayers-1-k]);
        return m;
    endfunction

    function automatic int max_rows();
        int m;
        m = ImageSize;
        for (int i = 0; i < NumLayers; i++)
            if (LNN[i] > m) m = LNN[i];
        return m;
    endfunction

    localparam int MaxRows = max_rows();
    localparam int RowW    = (MaxRows > 1) ? $clog2(MaxRows) : 1;
    localparam int LayerW  = (NumLayers > 1) ? $clog2(NumLayers) : 1;

endpackage

// File: rtl/dnn_lane_mask.sv
// Zeroes the weight lanes a layer does not use; the layer's nerves occupy
// the top lanes of the bus.
module dnn_lane_mask
    import dnn_pkg::*;
(
    input  logic [LayerW-1:0]                        layer,
    input  logic [MaxNumNerves-1:0][M_W_BitSize-1:0] row_in,
    output logic [MaxNumNerves-1:0][M_W_BitSize-1:0] row_out
);

    logic [MaxNumNerves-1:0] keep;

    always_comb begin
        keep    = lane_mask(int'(layer));
        row_out = '0;
        for (int i = 0; i < MaxNumNerves; i++)
            row_out[i] = keep[i] ? row_in[i] : '0;
    end

endmodule

// File: rtl/dnn_weight_loader.sv
// Handshaked weight-row scheduler: clears each systolic layer, then steers
// its rows to it through a one-hot strobe, layer by layer.
module dnn_weight_loader
    import dnn_pkg::*;
(
    input  logic                                     clk,
    input  logic                                     res_n,
    input  logic                                     start,
    input  logic                                     src_valid,
    input  logic [MaxNumNerves-1:0][M_W_BitSize-1:0] src_data,
    output logic                                     src_ready,
    output logic [MaxNumNerves-1:0][M_W_BitSize-1:0] out_weights,
    output logic [NumLayers-1:0]                     out_w_valid,
    output logic [NumLayers-1:0]                     out_layer_res_n,
    output logic                                     busy,
    output logic                                     done,
    output logic                                     loaded
);

    for (genvar i = 0; i < NumLayers; i++) begin : g_lnn_chk
        if (LNN[i] > MaxNumNerves || LNN[i] < 1) begin : g_bad
            $error("LNN entry outside 1..MaxNumNerves");
        end
    end
    if (ImageSize < 1) begin : g_bad_image
        $error("ImageSize must be at least 1");
    end

    weight_ld_state_t state, state_next;
    logic [LayerW-1:0] layer;
    logic [RowW-1:0]   row;
    logic              beat;
    logic              last_row;
    logic              last_layer;
    weight_row_t       masked;

    assign beat       = src_valid & src_ready;
    assign last_row   = (int'(row) == rows_for_layer(int'(layer)) - 1);
    assign last_layer = (int'(layer) == NumLayers - 1);

    dnn_lane_mask u_lane_mask (
        .layer   (layer),
        .row_in  (src_data),
        .row_out (masked)
    );

    always_ff @(posedge clk) begin
        if (!res_n)
            state <= IDLE;
        else
            state <= state_next;
    end

    always_comb begin
        state_next = state;
        unique case (state)
            IDLE:    if (start) state_next = CLEAR;
            CLEAR:   state_next = LOAD;
            LOAD:    if (beat && last_row) state_next = last_layer ? DONE : CLEAR;
            DONE:    state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    always_comb begin
        src_ready       = 1'b0;
        out_layer_res_n = '1;
        busy            = (state != IDLE);
        done            = 1'b0;
        case (state)
            CLEAR:   out_layer_res_n[layer] = 1'b0;
            LOAD:    src_ready = 1'b1;
            DONE:    done = 1'b1;
            default: ;
        endcase
    end

    // Row/layer counters and the registered output row (one cycle behind the beat).
    always_ff @(posedge clk) begin
        if (!res_n) begin
            layer       <= '0;
            row         <= '0;
            out_weights <= '0;
            out_w_valid <= '0;
            loaded      <= 1'b0;
        end else begin
            out_w_valid <= beat ? (NumLayers'(1) << layer) : '0;
            if (beat)
                out_weights <= masked;
            case (state)
                IDLE: if (start) begin
                    layer  <= '0;
                    loaded <= 1'b0;
                end
                CLEAR: row <= '0;
                LOAD: if (beat) begin
                    if (!last_row)
                        row <= row + RowW'(1);
                    else if (!last_layer)
                        layer <= layer + LayerW'(1);
                end
                DONE: loaded <= 1'b1;
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_dnn_weight_loader.sv
// Randomized scoreboard bench for dnn_weight_loader: a predictor turns each
// accepted beat into an expected strobe, a checker matches the DUT strobes.
module tb_dnn_weight_loader;
    import dnn_pkg::*;

    localparam int ROWS   [4] = '{16, 6, 5, 3};
    localparam int NERVES [4] = '{6, 5, 3, 2};
    localparam int TOTAL_ROWS = 30;

    typedef struct {
        logic [3:0]  oh;
        weight_row_t data;
    } exp_t;

    logic        clk;
    logic        res_n;
    logic        start;
    logic        src_valid;
    weight_row_t src_data;
    logic        src_ready;
    weight_row_t out_weights;
    logic [3:0]  out_w_valid;
    logic [3:0]  out_layer_res_n;
    logic        busy;
    logic        done;
    logic        loaded;

    int   total;
    int   bad;
    exp_t expq[$];
    int   beat_idx;
    int   cyc;
    int   exp_done_cyc;
    int   done_cnt;
    int   clr_cnt;
    int   strobe_cnt [4];

    dnn_weight_loader dut (
        .clk             (clk),
        .res_n           (res_n),
        .start           (start),
        .src_valid       (src_valid),
        .src_data        (src_data),
        .src_ready       (src_ready),
        .out_weights     (out_weights),
        .out_w_valid     (out_w_valid),
        .out_layer_res_n (out_layer_res_n),
        .busy            (busy),
        .done            (done),
        .loaded          (loaded)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    function automatic int layer_of(input int n);
        int acc;
        acc = 0;
        for (int k = 0; k < 4; k++) begin
            acc += ROWS[k];
            if (n < acc) return k;
        end
        return 3;
    endfunction

    function automatic weight_row_t mdl_mask(input weight_row_t d, input int k);
        weight_row_t r;
        r = '0;
        for (int i = 0; i < 6; i++)
            if (i >= 6 - NERVES[k]) r[i] = d[i];
        return r;
    endfunction

    function automatic weight_row_t rand_row();
        weight_row_t r;
        for (int i = 0; i < 6; i++) r[i] = 16'($urandom);
        return r;
    endfunction

    // Predictor: turns accepted beats into expected strobes and checks control.
    logic [3:0] p_em;
    exp_t       p_e;
    always @(negedge clk) begin
        if (res_n === 1'b1) begin
            if (start && !busy) begin
                cyc = 0;
                beat_idx = 0;
            end else begin
                cyc++;
            end
            if (!busy) chk("idle_ready", src_ready, 0);
            if (out_layer_res_n !== 4'hf) begin
                clr_cnt++;
                p_em = ~(4'b0001 << layer_of(beat_idx));
                chk("clear_mask", out_layer_res_n, p_em);
                chk("clear_ready", src_ready, 0);
            end
            if (src_valid && src_ready) begin
                p_e.oh   = 4'b0001 << layer_of(beat_idx);
                p_e.data = mdl_mask(src_data, layer_of(beat_idx));
                expq.push_back(p_e);
                beat_idx++;
            end
            if (done === 1'b1) begin
                done_cnt++;
                chk("done_beats", beat_idx, TOTAL_ROWS);
                if (exp_done_cyc >= 0) chk("done_cycle", cyc, exp_done_cyc);
                chk("done_loaded", loaded, 0);
            end
        end
    end

    // Checker: every DUT strobe must match the oldest expected entry.
    exp_t        c_e;
    weight_row_t last_w;
    always @(negedge clk) begin
        if ((|out_w_valid) === 1'b1) begin
            if (expq.size() == 0) begin
                chk("strobe_unexpected", out_w_valid, 0);
            end else begin
                c_e = expq.pop_front();
                chk("strobe_layer", out_w_valid, c_e.oh);
                chk("strobe_data", out_weights, c_e.data);
                for (int k = 0; k < 4; k++)
                    if (c_e.oh[k]) strobe_cnt[k]++;
                last_w = c_e.data;
            end
        end else if (res_n === 1'b1) begin
            chk("weights_hold", out_weights, last_w);
        end
        if (res_n !== 1'b1) last_w = '0;
    end

    task automatic chk_reset_outputs();
        chk("rst_src_ready", src_ready, 0);
        chk("rst_out_weights", out_weights, 0);
        chk("rst_out_w_valid", out_w_valid, 0);
        chk("rst_layer_res_n", out_layer_res_n, 4'hf);
        chk("rst_busy", busy, 0);
        chk("rst_done", done, 0);
        chk("rst_loaded", loaded, 0);
    endtask

    // mode 0: valid held high, 1: valid toggles, 2: valid high plus start noise,
    // 3: random valid. Called at posedge+1 with the DUT in IDLE.
    task automatic run_load(input int mode, input int exp_cyc);
        int guard;
        bit seen;
        for (int k = 0; k < 4; k++) strobe_cnt[k] = 0;
        done_cnt = 0;
        clr_cnt = 0;
        exp_done_cyc = exp_cyc;
        start = 1'b1;
        src_valid = 1'b0;
        @(posedge clk); #1;
        start = 1'b0;
        chk("start_busy", busy, 1);
        chk("start_loaded_clr", loaded, 0);
        seen = 1'b0;
        guard = 0;
        while (!seen && guard < 400) begin
            src_data = rand_row();
            case (mode)
                1:       src_valid = ~src_valid;
                3:       src_valid = 1'($urandom_range(0, 1));
                default: src_valid = 1'b1;
            endcase
            start = (mode == 2) ? 1'($urandom_range(0, 1)) : 1'b0;
            @(posedge clk); #1;
            guard++;
            if (done) begin
                seen = 1'b1;
                start = (mode == 2);
            end
        end
        if (!seen) chk("done_timeout", done, 1);
        @(posedge clk); #1;
        start = 1'b0;
        src_valid = 1'b0;
        chk("after_loaded", loaded, 1);
        chk("after_busy", busy, 0);
        chk("after_done", done, 0);
        for (int k = 0; k < 4; k++) chk($sformatf("strobes_l%0d", k), strobe_cnt[k], ROWS[k]);
        chk("done_pulses", done_cnt, 1);
        chk("clear_pulses", clr_cnt, 4);
        chk("queue_empty", expq.size(), 0);
    endtask

    task automatic run_reset_abort();
        int guard;
        start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        src_valid = 1'b1;
        guard = 0;
        while (beat_idx < 19 && guard < 100) begin
            src_data = rand_row();
            @(posedge clk); #1;
            guard++;
        end
        chk("abort_reached_l1r3", beat_idx, 19);
        res_n = 1'b0;
        @(posedge clk); #1;
        res_n = 1'b1;
        chk_reset_outputs();
        for (int i = 0; i < 5; i++) begin
            src_data = rand_row();
            @(posedge clk); #1;
            chk("abort_no_strobe", out_w_valid, 0);
        end
        src_valid = 1'b0;
        chk("abort_queue_empty", expq.size(), 0);
    endtask

    initial begin
        total = 0;
        bad = 0;
        beat_idx = 0;
        cyc = 0;
        exp_done_cyc = -1;
        done_cnt = 0;
        clr_cnt = 0;
        last_w = '0;
        for (int k = 0; k < 4; k++) strobe_cnt[k] = 0;
        res_n = 1'b0;
        start = 1'b0;
        src_valid = 1'b0;
        src_data = '0;
        repeat (2) @(posedge clk);
        #1;
        chk_reset_outputs();
        res_n = 1'b1;

        run_load(0, 35);
        run_load(0, 35);
        run_load(1, -1);
        run_load(2, 35);
        run_reset_abort();
        run_load(0, 35);
        run_load(3, -1);

        repeat (3) @(posedge clk);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

endmodule
